irda_codec: RTL and testbench



---
 rtl/irda_codec.sv | 216 +++++++++++++++++++++
 tb/tb_irda_codec.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irda_codec.sv
// IrDA SIR-style codec: turns a UART TX line into short IR pulses and
// stretches received IR pulses back into UART-width low bits.
//
// state    | meaning
// T_IDLE   | waiting for a start edge on the UART TX line
// T_ACTIVE | framing a UART character, emitting IR pulses for 0 bits
// T_GUARD  | blanking RX after TX so our own LED echo is not decoded
// R_IDLE   | uart_rx_data high, waiting for a qualified IR pulse
// R_LOW    | uart_rx_data held low for one bit time (retriggerable)
module irda_codec #(
   parameter int CLK_DIV        = 4,
   parameter int BIT_TICKS      = 16,
   parameter int PULSE_TICKS    = 3,
   parameter int MIN_PULSE_CLKS = 3,
   parameter int GUARD_TICKS    = 8,
   parameter int FRAME_BITS     = 10,
   parameter int RX_ACTIVE_LOW  = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sending,
   input  logic       uart_tx_data,
   output logic       ir_tx_data,
   input  logic       rx_ir_data,
   output logic       uart_rx_data,
   output logic       tx_active,
   output logic       rx_active,
   output logic [7:0] rx_glitch_cnt
);

   localparam int PULSE_CLKS   = PULSE_TICKS * CLK_DIV;
   localparam int STRETCH_CLKS = CLK_DIV * BIT_TICKS;
   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam int TICK_W  = $clog2(BIT_TICKS);
   localparam int BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int PULSE_W = $clog2(PULSE_CLKS);
   localparam int GUARD_W = (GUARD_TICKS > 0) ? $clog2(GUARD_TICKS + 1) : 1;
   localparam int STR_W   = $clog2(STRETCH_CLKS);
   localparam int RUN_W   = $clog2(MIN_PULSE_CLKS + 1);
   localparam logic RX_IDLE_LVL = (RX_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {T_IDLE, T_ACTIVE, T_GUARD} t_state_e;
   typedef enum logic {R_IDLE, R_LOW} r_state_e;

   t_state_e t_state_q, t_state_d;
   r_state_e r_state_q, r_state_d;
   logic [1:0]         tx_sync_q, tx_sync_d, rx_sync_q, rx_sync_d;
   logic               tx_prev_q, tx_prev_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
   logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [STR_W-1:0]   stretch_q, stretch_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic               qual_q, qual_d;
   logic               ir_q, ir_d, uart_rx_q, uart_rx_d;
   logic               tx_active_q, tx_active_d, rx_active_q, rx_active_d;
   logic [7:0]         glitch_q, glitch_d;

   logic tx_s, tx_fall, rx_act, tick, tx_start, pulse_start, blank;

   assign tx_s    = tx_sync_q[1];
   assign tx_fall = tx_prev_q & ~tx_s;
   assign rx_act  = (rx_sync_q[1] != RX_IDLE_LVL);
   assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
   // Our own TX (or the intent to send) would echo into the receiver.
   assign blank   = sending | (t_state_q != T_IDLE);

   // Synchronisers and oversample prescaler; the prescaler re-phases on a
   // TX start so bit timing is measured from the start edge.
   always_comb begin
      tx_sync_d = {tx_sync_q[0], uart_tx_data};
      rx_sync_d = {rx_sync_q[0], rx_ir_data};
      tx_prev_d = tx_s;
      div_d     = tick ? '0 : div_q + 1'b1;
      if (tx_start) div_d = '0;
   end

   // TX framing FSM: sample mid-bit, fire a fixed-width pulse for 0 bits.
   always_comb begin
      t_state_d   = t_state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      guard_cnt_d = guard_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      ir_d        = 1'b0;
      tx_start    = 1'b0;
      pulse_start = 1'b0;
      case (t_state_q)
         T_IDLE, T_GUARD: begin
            if (tx_fall && sending) begin
               tx_start   = 1'b1;
               t_state_d  = T_ACTIVE;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
            end else if (t_state_q == T_GUARD) begin
               if (guard_cnt_q == '0) t_state_d = T_IDLE;
               else if (tick)         guard_cnt_d = guard_cnt_q - 1'b1;
            end
         end
         T_ACTIVE: begin
            if (!sending) begin
               t_state_d   = T_GUARD;
               guard_cnt_d = GUARD_W'(GUARD_TICKS);
            end else begin
               if (tick) begin
                  if (tick_cnt_q == TICK_W'(BIT_TICKS - 1)) begin
                     tick_cnt_d = '0;
                     if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
                        t_state_d   = T_GUARD;
                        guard_cnt_d = GUARD_W'(GUARD_TICKS);
                     end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                     end
                  end else begin
                     tick_cnt_d = tick_cnt_q + 1'b1;
                  end
                  if (tick_cnt_q == TICK_W'(BIT_TICKS / 2 - 1) && !tx_s) pulse_start = 1'b1;
               end
               if (pulse_start) begin
                  ir_d        = 1'b1;
                  pulse_cnt_d = PULSE_W'(PULSE_CLKS - 1);
               end else if (ir_q && pulse_cnt_q != '0) begin
                  ir_d        = 1'b1;
                  pulse_cnt_d = pulse_cnt_q - 1'b1;
               end
               if (t_state_d != T_ACTIVE) ir_d = 1'b0;
            end
         end
         default: t_state_d = T_IDLE;
      endcase
      tx_active_d = (t_state_d == T_ACTIVE);
   end

   // RX pulse qualifier, glitch counter and retriggerable low-stretch FSM.
   always_comb begin
      run_d     = run_q;
      glitch_d  = glitch_q;
      r_state_d = r_state_q;
      stretch_d = stretch_q;
      if (!rx_act)                                run_d = '0;
      else if (run_q != RUN_W'(MIN_PULSE_CLKS))   run_d = run_q + 1'b1;
      qual_d = rx_act && (run_q == RUN_W'(MIN_PULSE_CLKS - 1));
      if (!rx_act && run_q != '0 && run_q < RUN_W'(MIN_PULSE_CLKS) && !blank
          && glitch_q != 8'hFF)
         glitch_d = glitch_q + 1'b1;
      case (r_state_q)
         R_IDLE: begin
            if (qual_q && !blank) begin
               r_state_d = R_LOW;
               stretch_d = STR_W'(STRETCH_CLKS - 1);
            end
         end
         R_LOW: begin
            if (blank)                r_state_d = R_IDLE;
            else if (qual_q)          stretch_d = STR_W'(STRETCH_CLKS - 1);
            else if (stretch_q == '0) r_state_d = R_IDLE;
            else                      stretch_d = stretch_q - 1'b1;
         end
         default: r_state_d = R_IDLE;
      endcase
      uart_rx_d   = (r_state_d != R_LOW);
      rx_active_d = (r_state_d == R_LOW);
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         t_state_q   <= T_IDLE;
         r_state_q   <= R_IDLE;
         tx_sync_q   <= 2'b11;
         tx_prev_q   <= 1'b1;
         rx_sync_q   <= {2{RX_IDLE_LVL}};
         div_q       <= '0;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         guard_cnt_q <= '0;
         pulse_cnt_q <= '0;
         stretch_q   <= '0;
         run_q       <= '0;
         qual_q      <= 1'b0;
         ir_q        <= 1'b0;
         uart_rx_q   <= 1'b1;
         tx_active_q <= 1'b0;
         rx_active_q <= 1'b0;
         glitch_q    <= '0;
      end else begin
         t_state_q   <= t_state_d;
         r_state_q   <= r_state_d;
         tx_sync_q   <= tx_sync_d;
         tx_prev_q   <= tx_prev_d;
         rx_sync_q   <= rx_sync_d;
         div_q       <= div_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         guard_cnt_q <= guard_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         stretch_q   <= stretch_d;
         run_q       <= run_d;
         qual_q      <= qual_d;
         ir_q        <= ir_d;
         uart_rx_q   <= uart_rx_d;
         tx_active_q <= tx_active_d;
         rx_active_q <= rx_active_d;
         glitch_q    <= glitch_d;
      end
   end

   assign ir_tx_data    = ir_q;
   assign uart_rx_data  = uart_rx_q;
   assign tx_active     = tx_active_q;
   assign rx_active     = rx_active_q;
   assign rx_glitch_cnt = glitch_q;

endmodule

// File: tb/tb_irda_codec.sv
// Bench for irda_codec at default parameters. Inputs are driven 1ns after
// the rising edge, outputs sampled on the falling edge. Step t's inputs are
// first seen by the rising edge of step t+1.
module tb_irda_codec;
   localparam int BIT_CLKS   = 64;   // CLK_DIV * BIT_TICKS
   localparam int SAMPLE_OFS = 32;   // mid-bit: BIT_TICKS/2 ticks
   localparam int PULSE_CLKS = 12;   // PULSE_TICKS * CLK_DIV
   localparam int FRAME_CLKS = 640;  // FRAME_BITS bit times
   localparam int START_LAT  = 3;    // two sync flops + registered start
   localparam int MIN_PULSE  = 3;
   localparam int RX_LAT     = MIN_PULSE + 3;
   localparam int STRETCH    = 64;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sending = 1'b0;
   logic       uart_tx_data = 1'b1;
   logic       rx_ir_data = 1'b1;
   logic       ir_tx_data, uart_rx_data, tx_active, rx_active;
   logic [7:0] rx_glitch_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int exp_glitch = 0;
   int pa[$];
   int pl[$];

   irda_codec dut (
      .clock(clock), .reset(reset), .sending(sending),
      .uart_tx_data(uart_tx_data), .ir_tx_data(ir_tx_data),
      .rx_ir_data(rx_ir_data), .uart_rx_data(uart_rx_data),
      .tx_active(tx_active), .rx_active(rx_active),
      .rx_glitch_cnt(rx_glitch_cnt)
   );

   always #5 clock = ~clock;

   task automatic test_reset();
      repeat (3) @(negedge clock);
      n_cmp++; if (ir_tx_data !== 1'b0) begin n_err++; $display("FAIL rst_ir got=%b exp=0", ir_tx_data); end
      n_cmp++; if (uart_rx_data !== 1'b1) begin n_err++; $display("FAIL rst_uart_rx got=%b exp=1", uart_rx_data); end
      n_cmp++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL rst_tx_active got=%b exp=0", tx_active); end
      n_cmp++; if (rx_active !== 1'b0) begin n_err++; $display("FAIL rst_rx_active got=%b exp=0", rx_active); end
      n_cmp++; if (rx_glitch_cnt !== 8'd0) begin n_err++; $display("FAIL rst_glitch got=%0d exp=0", rx_glitch_cnt); end
      reset = 1'b0;
   endtask

   // One UART frame of byte d; abort_at >= 0 drops sending at that step.
   task automatic tx_frame(input logic [7:0] d, input int abort_at, input int gap);
      logic [9:0] fr;
      int rel, b, o, npulse, exp_np;
      logic e_act, e_ir, prev_ir;
      fr = {1'b1, d, 1'b0};
      exp_np = 0;
      for (int i = 0; i < 10; i++) if (!fr[i]) exp_np++;
      for (int g = 0; g < gap; g++) begin
         @(posedge clock); #1; sending = 1'b1; uart_tx_data = 1'b1;
         @(negedge clock);
         n_cmp++;
         if (ir_tx_data !== 1'b0 || tx_active !== 1'b0) begin
            n_err++; $display("FAIL tx_gap ir=%b act=%b exp=0/0", ir_tx_data, tx_active);
         end
      end
      npulse = 0; prev_ir = 1'b0;
      for (int t = 0; t < 700; t++) begin
         @(posedge clock); #1;
         uart_tx_data = (t < FRAME_CLKS) ? fr[t / BIT_CLKS] : 1'b1;
         sending = (abort_at >= 0 && t >= abort_at) ? 1'b0 : 1'b1;
         @(negedge clock);
         rel = t - START_LAT;
         e_act = (rel >= 0) && (rel < FRAME_CLKS) && ((abort_at < 0) || (t <= abort_at));
         e_ir = 1'b0;
         if (e_act) begin
            b = rel / BIT_CLKS; o = rel % BIT_CLKS;
            e_ir = !fr[b] && (o >= SAMPLE_OFS) && (o < SAMPLE_OFS + PULSE_CLKS);
         end
         n_cmp++;
         if (ir_tx_data !== e_ir) begin
            n_err++; $display("FAIL tx_ir byte=%h t=%0d got=%b exp=%b", d, t, ir_tx_data, e_ir);
         end
         n_cmp++;
         if (tx_active !== e_act) begin
            n_err++; $display("FAIL tx_active byte=%h t=%0d got=%b exp=%b", d, t, tx_active, e_act);
         end
         if (ir_tx_data === 1'b1 && !prev_ir) npulse++;
         prev_ir = (ir_tx_data === 1'b1);
      end
      if (abort_at < 0) begin
         n_cmp++;
         if (npulse != exp_np) begin
            n_err++; $display("FAIL tx_pulse_count byte=%h got=%0d exp=%0d", d, npulse, exp_np);
         end
      end
   endtask

   task automatic test_tx_frames();
      tx_frame(8'h55, -1, 10);
      for (int k = 0; k < 3; k++)
         tx_frame(8'($urandom_range(0, 255)), -1, int'($urandom_range(3, 40)));
   endtask

   task automatic test_tx_abort();
      int b;
      b = int'($urandom_range(0, 8));
      tx_frame(8'h00, b * BIT_CLKS + START_LAT + SAMPLE_OFS + 6, 5);
   endtask

   // Replays pulses pa/pl (start step, length) with TX idle and sending=0.
   task automatic rx_run(input int total, output int nlow);
      logic act, elow;
      int ng;
      nlow = 0;
      for (int t = 0; t < total; t++) begin
         @(posedge clock); #1;
         sending = 1'b0;
         act = 1'b0;
         foreach (pa[i]) if (t >= pa[i] && t < pa[i] + pl[i]) act = 1'b1;
         rx_ir_data = ~act;
         @(negedge clock);
         elow = 1'b0;
         foreach (pa[i])
            if (pl[i] >= MIN_PULSE && t >= pa[i] + RX_LAT && t < pa[i] + RX_LAT + STRETCH) elow = 1'b1;
         if (uart_rx_data === 1'b0) nlow++;
         n_cmp++;
         if (uart_rx_data !== ~elow) begin
            n_err++; $display("FAIL rx_uart t=%0d got=%b exp=%b", t, uart_rx_data, ~elow);
         end
         n_cmp++;
         if (rx_active !== elow) begin
            n_err++; $display("FAIL rx_active t=%0d got=%b exp=%b", t, rx_active, elow);
         end
      end
      ng = 0;
      foreach (pl[i]) if (pl[i] >= 1 && pl[i] < MIN_PULSE) ng++;
      exp_glitch = (exp_glitch + ng > 255) ? 255 : exp_glitch + ng;
      n_cmp++;
      if (rx_glitch_cnt !== 8'(exp_glitch)) begin
         n_err++; $display("FAIL rx_glitch got=%0d exp=%0d", rx_glitch_cnt, exp_glitch);
      end
   endtask

   task automatic test_rx_single();
      int nlow;
      pa = {60}; pl = {3};
      rx_run(200, nlow);
      n_cmp++;
      if (nlow != STRETCH) begin n_err++; $display("FAIL rx_single_len got=%0d exp=%0d", nlow, STRETCH); end
   endtask

   task automatic test_rx_retrigger();
      int nlow;
      pa = {60, 60 + STRETCH}; pl = {3, 3};
      rx_run(300, nlow);
      n_cmp++;
      if (nlow != 2 * STRETCH) begin n_err++; $display("FAIL rx_retrig_len got=%0d exp=%0d", nlow, 2 * STRETCH); end
   endtask

   task automatic test_rx_random();
      int t0, nlow;
      pa = {}; pl = {};
      t0 = 60;
      for (int i = 0; i < 14; i++) begin
         pa.push_back(t0);
         pl.push_back(int'($urandom_range(1, 5)));
         t0 = t0 + pl[i] + int'($urandom_range(1, 90));
      end
      rx_run(t0 + 100, nlow);
   endtask

   task automatic test_rx_glitch();
      int nlow;
      pa = {60, 70, 80}; pl = {2, 2, 2};
      rx_run(150, nlow);
      n_cmp++;
      if (rx_glitch_cnt !== 8'd3) begin n_err++; $display("FAIL rx_glitch3 got=%0d exp=3", rx_glitch_cnt); end
      pa = {}; pl = {};
      for (int i = 0; i < 300; i++) begin pa.push_back(60 + 5 * i); pl.push_back(2); end
      rx_run(60 + 1500 + 50, nlow);
   endtask

   task automatic test_blanking();
      logic [9:0] fr;
      logic act, e_act;
      // Receiver blanked by sending=1 with TX idle.
      for (int t = 0; t < 150; t++) begin
         @(posedge clock); #1;
         sending = 1'b1; uart_tx_data = 1'b1;
         rx_ir_data = ~((t >= 10 && t < 13) || (t >= 30 && t < 32));
         @(negedge clock);
         n_cmp++;
         if (uart_rx_data !== 1'b1 || rx_active !== 1'b0) begin
            n_err++; $display("FAIL blank_send t=%0d uart_rx=%b rx_act=%b exp=1/0", t, uart_rx_data, rx_active);
         end
      end
      // Receiver blanked by the guard window right after a frame.
      fr = {1'b1, 8'hFF, 1'b0};
      for (int t = 0; t < 800; t++) begin
         @(posedge clock); #1;
         uart_tx_data = (t < FRAME_CLKS) ? fr[t / BIT_CLKS] : 1'b1;
         sending = (t < FRAME_CLKS + START_LAT);
         act = (t >= 648 && t < 651) || (t >= 658 && t < 660);
         rx_ir_data = ~act;
         @(negedge clock);
         e_act = (t >= START_LAT) && (t < FRAME_CLKS + START_LAT);
         n_cmp++;
         if (tx_active !== e_act) begin
            n_err++; $display("FAIL guard_tx_active t=%0d got=%b exp=%b", t, tx_active, e_act);
         end
         n_cmp++;
         if (uart_rx_data !== 1'b1 || rx_active !== 1'b0) begin
            n_err++; $display("FAIL blank_guard t=%0d uart_rx=%b rx_act=%b exp=1/0", t, uart_rx_data, rx_active);
         end
      end
      n_cmp++;
      if (rx_glitch_cnt !== 8'(exp_glitch)) begin
         n_err++; $display("FAIL blank_glitch got=%0d exp=%0d", rx_glitch_cnt, exp_glitch);
      end
   endtask

   task automatic test_reset_mid();
      // Mid R_LOW.
      for (int t = 0; t <= 40; t++) begin
         @(posedge clock); #1;
         sending = 1'b0;
         rx_ir_data = ~(t >= 5 && t < 8);
         @(negedge clock);
      end
      n_cmp++;
      if (uart_rx_data !== 1'b0) begin n_err++; $display("FAIL rstmid_rx_pre got=%b exp=0", uart_rx_data); end
      reset = 1'b1; #1;
      n_cmp++;
      if (uart_rx_data !== 1'b1 || rx_active !== 1'b0) begin
         n_err++; $display("FAIL rstmid_rx_async uart_rx=%b rx_act=%b exp=1/0", uart_rx_data, rx_active);
      end
      n_cmp++;
      if (rx_glitch_cnt !== 8'd0) begin n_err++; $display("FAIL rstmid_glitch got=%0d exp=0", rx_glitch_cnt); end
      exp_glitch = 0;
      @(negedge clock); reset = 1'b0;
      for (int t = 0; t < 150; t++) begin
         @(posedge clock); #1; rx_ir_data = 1'b1;
         @(negedge clock);
         n_cmp++;
         if (uart_rx_data !== 1'b1 || rx_active !== 1'b0) begin
            n_err++; $display("FAIL rstmid_rx_after t=%0d uart_rx=%b rx_act=%b exp=1/0", t, uart_rx_data, rx_active);
         end
      end
      // Mid TX pulse (start bit pulse spans steps 35..46).
      for (int t = 0; t <= 40; t++) begin
         @(posedge clock); #1;
         sending = 1'b1; uart_tx_data = 1'b0;
         @(negedge clock);
      end
      n_cmp++;
      if (ir_tx_data !== 1'b1 || tx_active !== 1'b1) begin
         n_err++; $display("FAIL rstmid_tx_pre ir=%b act=%b exp=1/1", ir_tx_data, tx_active);
      end
      uart_tx_data = 1'b1;
      reset = 1'b1; #1;
      n_cmp++;
      if (ir_tx_data !== 1'b0 || tx_active !== 1'b0) begin
         n_err++; $display("FAIL rstmid_tx_async ir=%b act=%b exp=0/0", ir_tx_data, tx_active);
      end
      @(negedge clock); reset = 1'b0;
      for (int t = 0; t < 150; t++) begin
         @(posedge clock); #1; uart_tx_data = 1'b1;
         @(negedge clock);
         n_cmp++;
         if (ir_tx_data !== 1'b0 || tx_active !== 1'b0) begin
            n_err++; $display("FAIL rstmid_tx_after t=%0d ir=%b act=%b exp=0/0", t, ir_tx_data, tx_active);
         end
      end
   endtask

   initial begin
      test_reset();
      test_tx_frames();
      test_tx_abort();
      test_rx_single();
      test_rx_retrigger();
      test_rx_random();
      test_blanking();
      test_reset_mid();
      test_rx_glitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
